// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - multi-cycle data memory responder with fixed-latency stall/done handshake
`timescale 1ns/1ps
module dmem_responder #(
    parameter int DEPTH     = 64,
    parameter int ADDR_BITS = 6,
    parameter int LATENCY   = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] address,
    input  logic [31:0] Write_data,
    output logic [31:0] Read_data,
    output logic        stall,
    output logic        done,
    output logic        misaligned,
    input  logic [31:0] dbg_addr,
    output logic [31:0] dbg_data
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                 state;
    state_t                 state_next;
    logic [3:0]             cnt;
    logic                   op_write;
    logic [ADDR_BITS-1:0]   op_idx;
    logic [31:0]            op_data;
    logic [31:0]            mem [DEPTH];

    logic                   request;
    logic                   accept;
    logic                   commit;
    logic                   commit_write;
    logic [ADDR_BITS-1:0]   commit_idx;
    logic [31:0]            commit_data;
    logic                   unused_bits;

    assign request = MemRead | MemWrite;
    assign accept  = (state == IDLE) && request;
    assign commit  = (state_next == DONE);

    // With LATENCY=1 the commit happens on the accept edge, before the latches are loaded.
    assign commit_write = (state == IDLE) ? MemWrite : op_write;
    assign commit_idx   = (state == IDLE) ? address[ADDR_BITS+1:2] : op_idx;
    assign commit_data  = (state == IDLE) ? Write_data : op_data;

    assign dbg_data    = mem[dbg_addr[ADDR_BITS+1:2]];
    assign unused_bits = ^{address[31:ADDR_BITS+2], dbg_addr[31:ADDR_BITS+2], dbg_addr[1:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (request) begin
                    state_next = (LATENCY == 1) ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (cnt == 4'd1) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        stall = 1'b0;
        done  = 1'b0;
        case (state)
            IDLE:    stall = request;
            BUSY:    stall = 1'b1;
            DONE:    done  = 1'b1;
            default: ;
        endcase
    end

    // cnt holds the number of BUSY cycles still to run; the accept cycle is the first stall cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= '0;
            op_write <= 1'b0;
            op_idx   <= '0;
            op_data  <= '0;
        end else if (accept) begin
            cnt      <= 4'(LATENCY - 1);
            op_write <= MemWrite;
            op_idx   <= address[ADDR_BITS+1:2];
            op_data  <= Write_data;
        end else if (state == BUSY) begin
            cnt <= cnt - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            Read_data <= '0;
        end else if (commit) begin
            if (commit_write) begin
                mem[commit_idx] <= commit_data;
            end else begin
                Read_data <= mem[commit_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            misaligned <= 1'b0;
        end else if (accept && (address[1:0] != 2'b00)) begin
            misaligned <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed scoreboard bench for dmem_responder
`timescale 1ns/1ps
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] address;
    logic [31:0] Write_data;
    logic [31:0] Read_data;
    logic        stall;
    logic        done;
    logic        misaligned;
    logic [31:0] dbg_addr;
    logic [31:0] dbg_data;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] model [64];
    logic [31:0] exp_q [$];
    logic [31:0] last_rd;
    int          cyc_a;
    int          cyc_b;

    dmem_responder #(.DEPTH(64), .ADDR_BITS(6), .LATENCY(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .address    (address),
        .Write_data (Write_data),
        .Read_data  (Read_data),
        .stall      (stall),
        .done       (done),
        .misaligned (misaligned),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 64; i++) model[i] = '0;
        last_rd = '0;
        exp_q.delete();
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0;
        model_clear();
        @(posedge clk);
        @(negedge clk);
        check("rst_stall", {31'b0, stall}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_read_data", Read_data, 32'd0);
        check("rst_misaligned", {31'b0, misaligned}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk); #1;
        MemRead = 1'b0; MemWrite = 1'b0;
        @(negedge clk);
        check("idle_stall", {31'b0, stall}, 32'd0);
        check("idle_done", {31'b0, done}, 32'd0);
    endtask

    // Leaves the request asserted through DONE, as the EX/MEM register would.
    task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] data, output int cycles);
        int stalls;
        logic [5:0] idx;
        idx = 6'((addr >> 2) % 64);
        @(posedge clk); #1;
        MemRead = rd; MemWrite = wr; address = addr; Write_data = data;
        if (wr) begin
            exp_q.push_back(last_rd);
            model[idx] = data;
        end else begin
            exp_q.push_back(model[idx]);
            last_rd = model[idx];
        end
        @(negedge clk);
        cycles = 1;
        stalls = stall ? 1 : 0;
        check("accept_stall", {31'b0, stall}, 32'd1);
        check("accept_done_low", {31'b0, done}, 32'd0);
        while (!done && cycles < 20) begin
            @(negedge clk);
            cycles++;
            if (stall) stalls++;
            if (cycles == 2) begin
                address = ~addr; Write_data = ~data;
            end
        end
        address = addr; Write_data = data;
        check("done_seen", {31'b0, done}, 32'd1);
        check("stall_cycles", 32'(stalls), 32'd3);
        check("done_stall_low", {31'b0, stall}, 32'd0);
        check("read_data", Read_data, exp_q.pop_front());
    endtask

    initial begin
        reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0;
        address = '0; Write_data = '0; dbg_addr = '0;
        do_reset();
        #1 check("rst_dbg_data", dbg_data, 32'd0);

        access(1'b1, 1'b0, 32'h10, 32'h0, cyc_a);
        check("read_latency", 32'(cyc_a), 32'd4);
        check("aligned_misaligned", {31'b0, misaligned}, 32'd0);
        idle();

        access(1'b0, 1'b1, 32'h08, 32'hDEADBEEF, cyc_a);
        idle();
        dbg_addr = 32'h08;
        #1 check("dbg_after_write", dbg_data, 32'hDEADBEEF);
        access(1'b1, 1'b0, 32'h08, 32'h0, cyc_a);
        idle();

        access(1'b0, 1'b1, 32'h00, 32'h1, cyc_a);
        access(1'b1, 1'b0, 32'h00, 32'h0, cyc_b);
        check("back_to_back_cycles", 32'(cyc_a + cyc_b), 32'd8);
        idle();

        access(1'b0, 1'b1, 32'h102, 32'hA5, cyc_a);
        check("misaligned_set", {31'b0, misaligned}, 32'd1);
        idle();
        access(1'b1, 1'b0, 32'h00, 32'h0, cyc_a);
        check("misaligned_sticky", {31'b0, misaligned}, 32'd1);
        idle();

        access(1'b1, 1'b1, 32'h0C, 32'h7, cyc_a);
        idle();
        dbg_addr = 32'h0C;
        #1 check("both_high_dbg", dbg_data, 32'h7);
        access(1'b1, 1'b0, 32'h0C, 32'h0, cyc_a);
        idle();

        @(posedge clk); #1;
        MemWrite = 1'b1; address = 32'h04; Write_data = 32'h55;
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b1; MemWrite = 1'b0;
        model_clear();
        @(posedge clk);
        @(negedge clk);
        check("abort_stall", {31'b0, stall}, 32'd0);
        check("abort_done", {31'b0, done}, 32'd0);
        check("abort_misaligned", {31'b0, misaligned}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        dbg_addr = 32'h04;
        #1 check("abort_dbg", dbg_data, 32'd0);
        access(1'b1, 1'b0, 32'h04, 32'h0, cyc_a);
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
